// File: rtl/axi4_slave_mem.sv
// AXI4 slave with an internal word-addressed memory. It serves FIXED and INCR
// bursts of up to 256 beats and answers bad or out-of-range requests with
// SLVERR. The read and write engines are independent, and each one keeps a
// single transaction outstanding.
module axi4_slave_mem #(
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_WORDS = 1024
) (
  input  logic              ACLK,
  input  logic              ARESET,
  // write address channel
  input  logic [ID_W-1:0]   S_AXI_AWID,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic [7:0]        S_AXI_AWLEN,
  input  logic [2:0]        S_AXI_AWSIZE,
  input  logic [1:0]        S_AXI_AWBURST,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  // write data channel
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WLAST,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  // write response channel
  output logic [ID_W-1:0]   S_AXI_BID,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  // read address channel
  input  logic [ID_W-1:0]   S_AXI_ARID,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic [7:0]        S_AXI_ARLEN,
  input  logic [2:0]        S_AXI_ARSIZE,
  input  logic [1:0]        S_AXI_ARBURST,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  // read data channel
  output logic [ID_W-1:0]   S_AXI_RID,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RLAST,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY
);

  localparam int         IDX_W       = $clog2(MEM_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
  typedef enum logic       {R_IDLE, R_DATA}         rState_t;

  logic [31:0] mem [MEM_WORDS];

  // A beat is in range when its word index lies below the memory depth.
  function automatic logic inRange(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:2] < (ADDR_W-2)'(MEM_WORDS);
  endfunction

  function automatic logic [IDX_W-1:0] wordIdx(input logic [ADDR_W-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  // Only 32-bit beats and the FIXED and INCR burst types are supported.
  function automatic logic badReq(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'b010) || burst[1];
  endfunction

  function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] a,
                                                 input logic fixed);
    return fixed ? a : a + ADDR_W'(4);
  endfunction

  // ---------------------------------------------------------------------------
  // Write engine
  // ---------------------------------------------------------------------------
  wState_t           wState_q, wState_d;
  logic [ID_W-1:0]   wId_q, wId_d;
  logic [ADDR_W-1:0] wAddr_q, wAddr_d;
  logic [7:0]        wLen_q, wLen_d;
  logic [7:0]        wBeat_q, wBeat_d;
  logic              wErr_q, wErr_d;
  logic              wFixed_q, wFixed_d;
  logic              awReady_q, wReady_q, bValid_q;
  logic              memWe;
  logic              wLastBeat;
  logic              wBeatInRange;

  assign wLastBeat    = (wBeat_q == wLen_q);
  assign wBeatInRange = inRange(wAddr_q);

  // Write next-state logic: the beat counter ends the burst, and any WLAST
  // disagreement or out-of-range beat poisons the response.
  always_comb begin
    wState_d = wState_q;
    wId_d    = wId_q;
    wAddr_d  = wAddr_q;
    wLen_d   = wLen_q;
    wBeat_d  = wBeat_q;
    wErr_d   = wErr_q;
    wFixed_d = wFixed_q;
    memWe    = 1'b0;
    case (wState_q)
      W_IDLE: begin
        if (S_AXI_AWVALID && awReady_q) begin
          wId_d    = S_AXI_AWID;
          wAddr_d  = S_AXI_AWADDR;
          wLen_d   = S_AXI_AWLEN;
          wBeat_d  = 8'd0;
          wErr_d   = badReq(S_AXI_AWSIZE, S_AXI_AWBURST);
          wFixed_d = (S_AXI_AWBURST == 2'b00);
          wState_d = W_DATA;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID && wReady_q) begin
          memWe  = wBeatInRange && !wErr_q;
          wErr_d = wErr_q || !wBeatInRange || (S_AXI_WLAST != wLastBeat);
          if (wLastBeat) begin
            wState_d = W_RESP;
          end else begin
            wBeat_d = wBeat_q + 8'd1;
            wAddr_d = nextAddr(wAddr_q, wFixed_q);
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY && bValid_q) begin
          wState_d = W_IDLE;
        end
      end
      default: wState_d = W_IDLE;
    endcase
  end

  // Write state register. The handshake outputs are registered from the next
  // state, so all of them read 0 while reset is held.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wState_q  <= W_IDLE;
      wId_q     <= '0;
      wAddr_q   <= '0;
      wLen_q    <= '0;
      wBeat_q   <= '0;
      wErr_q    <= 1'b0;
      wFixed_q  <= 1'b0;
      awReady_q <= 1'b0;
      wReady_q  <= 1'b0;
      bValid_q  <= 1'b0;
    end else begin
      wState_q  <= wState_d;
      wId_q     <= wId_d;
      wAddr_q   <= wAddr_d;
      wLen_q    <= wLen_d;
      wBeat_q   <= wBeat_d;
      wErr_q    <= wErr_d;
      wFixed_q  <= wFixed_d;
      awReady_q <= (wState_d == W_IDLE);
      wReady_q  <= (wState_d == W_DATA);
      bValid_q  <= (wState_d == W_RESP);
    end
  end

  // Memory array write port with byte enables. The array has no reset.
  always_ff @(posedge ACLK) begin
    if (memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (S_AXI_WSTRB[b]) begin
          mem[wordIdx(wAddr_q)][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  assign S_AXI_AWREADY = awReady_q;
  assign S_AXI_WREADY  = wReady_q;
  assign S_AXI_BVALID  = bValid_q;
  assign S_AXI_BID     = wId_q;
  assign S_AXI_BRESP   = (bValid_q && wErr_q) ? RESP_SLVERR : RESP_OKAY;

  // ---------------------------------------------------------------------------
  // Read engine
  // ---------------------------------------------------------------------------
  rState_t           rState_q, rState_d;
  logic [ID_W-1:0]   rId_q, rId_d;
  logic [ADDR_W-1:0] rAddr_q, rAddr_d;
  logic [7:0]        rLen_q, rLen_d;
  logic [7:0]        rBeat_q, rBeat_d;
  logic              rErr_q, rErr_d;
  logic              rFixed_q, rFixed_d;
  logic              arReady_q, rValid_q, rLast_q;
  logic [31:0]       rData_q;
  logic [1:0]        rResp_q;
  logic              fetch;
  logic [ADDR_W-1:0] fetchAddr;
  logic              fetchErr;
  logic              fetchLast;
  logic              fetchOk;
  logic [ADDR_W-1:0] rNextAddr;

  assign rNextAddr = nextAddr(rAddr_q, rFixed_q);
  assign fetchOk   = !fetchErr && inRange(fetchAddr);

  // Read next-state logic. A beat is fetched on the AR handshake and again on
  // each accepted R beat, so the registered R payload holds still while the
  // master stalls.
  always_comb begin
    rState_d  = rState_q;
    rId_d     = rId_q;
    rAddr_d   = rAddr_q;
    rLen_d    = rLen_q;
    rBeat_d   = rBeat_q;
    rErr_d    = rErr_q;
    rFixed_d  = rFixed_q;
    fetch     = 1'b0;
    fetchAddr = rAddr_q;
    fetchErr  = rErr_q;
    fetchLast = 1'b0;
    case (rState_q)
      R_IDLE: begin
        if (S_AXI_ARVALID && arReady_q) begin
          rId_d     = S_AXI_ARID;
          rAddr_d   = S_AXI_ARADDR;
          rLen_d    = S_AXI_ARLEN;
          rBeat_d   = 8'd0;
          rErr_d    = badReq(S_AXI_ARSIZE, S_AXI_ARBURST);
          rFixed_d  = (S_AXI_ARBURST == 2'b00);
          fetch     = 1'b1;
          fetchAddr = S_AXI_ARADDR;
          fetchErr  = badReq(S_AXI_ARSIZE, S_AXI_ARBURST);
          fetchLast = (S_AXI_ARLEN == 8'd0);
          rState_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY && rValid_q) begin
          if (rBeat_q == rLen_q) begin
            rState_d = R_IDLE;
          end else begin
            rBeat_d   = rBeat_q + 8'd1;
            rAddr_d   = rNextAddr;
            fetch     = 1'b1;
            fetchAddr = rNextAddr;
            fetchLast = ((rBeat_q + 8'd1) == rLen_q);
          end
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  // Read state register and R payload. A fetch that coincides with a write to
  // the same word sees the old contents.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rState_q  <= R_IDLE;
      rId_q     <= '0;
      rAddr_q   <= '0;
      rLen_q    <= '0;
      rBeat_q   <= '0;
      rErr_q    <= 1'b0;
      rFixed_q  <= 1'b0;
      arReady_q <= 1'b0;
      rValid_q  <= 1'b0;
      rLast_q   <= 1'b0;
      rData_q   <= '0;
      rResp_q   <= RESP_OKAY;
    end else begin
      rState_q  <= rState_d;
      rId_q     <= rId_d;
      rAddr_q   <= rAddr_d;
      rLen_q    <= rLen_d;
      rBeat_q   <= rBeat_d;
      rErr_q    <= rErr_d;
      rFixed_q  <= rFixed_d;
      arReady_q <= (rState_d == R_IDLE);
      rValid_q  <= (rState_d == R_DATA);
      if (fetch) begin
        rData_q <= fetchOk ? mem[wordIdx(fetchAddr)] : 32'd0;
        rResp_q <= fetchOk ? RESP_OKAY : RESP_SLVERR;
        rLast_q <= fetchLast;
      end
    end
  end

  assign S_AXI_ARREADY = arReady_q;
  assign S_AXI_RVALID  = rValid_q;
  assign S_AXI_RID     = rId_q;
  assign S_AXI_RDATA   = rData_q;
  assign S_AXI_RRESP   = rResp_q;
  assign S_AXI_RLAST   = rLast_q;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed testbench for axi4_slave_mem. Bus tasks drive the inputs and sample
// the outputs on the falling clock edge. Expected values are written by hand.
module tb_axi4_slave_mem;

  localparam int ADDR_W    = 32;
  localparam int ID_W      = 4;
  localparam int MEM_WORDS = 1024;
  localparam int TIMEOUT   = 200;

  logic              ACLK;
  logic              ARESET;
  logic [ID_W-1:0]   S_AXI_AWID;
  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic [7:0]        S_AXI_AWLEN;
  logic [2:0]        S_AXI_AWSIZE;
  logic [1:0]        S_AXI_AWBURST;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WLAST;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [ID_W-1:0]   S_AXI_BID;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [ID_W-1:0]   S_AXI_ARID;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic [7:0]        S_AXI_ARLEN;
  logic [2:0]        S_AXI_ARSIZE;
  logic [1:0]        S_AXI_ARBURST;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [ID_W-1:0]   S_AXI_RID;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RLAST;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0]     wrBuf  [256];
  logic [31:0]     rdData [256];
  logic [31:0]     stData [256];
  logic [1:0]      rdResp [256];
  logic            rdLast [256];
  logic [ID_W-1:0] rdId   [256];

  logic [1:0]      bResp;
  logic [ID_W-1:0] bId;

  axi4_slave_mem #(.ADDR_W(ADDR_W), .ID_W(ID_W), .MEM_WORDS(MEM_WORDS)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  // 100 MHz free-running clock
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Hard stop in case a handshake never completes
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] allOutputs();
    return {14'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_BID,
            S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RID};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic sendAw(input logic [ID_W-1:0] id, input logic [31:0] addr,
                        input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
    S_AXI_AWSIZE = size; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
    while (!S_AXI_AWREADY && n < TIMEOUT) begin @(negedge ACLK); n++; end
    if (n >= TIMEOUT) checkOutput("awReadyTimeout", 64'(n), 64'd0);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
  endtask

  task automatic sendAr(input logic [ID_W-1:0] id, input logic [31:0] addr,
                        input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
    S_AXI_ARSIZE = size; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
    while (!S_AXI_ARREADY && n < TIMEOUT) begin @(negedge ACLK); n++; end
    if (n >= TIMEOUT) checkOutput("arReadyTimeout", 64'(n), 64'd0);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
  endtask

  // Full write burst using wrBuf as data; WLAST is raised on beat lastAt.
  task automatic applyStimulus(input logic [ID_W-1:0] id, input logic [31:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [3:0] strb,
                               input int lastAt,
                               output logic [1:0] resp, output logic [ID_W-1:0] rid);
    int n;
    sendAw(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      S_AXI_WDATA = wrBuf[i]; S_AXI_WSTRB = strb;
      S_AXI_WLAST = (i == lastAt); S_AXI_WVALID = 1'b1;
      n = 0;
      while (!S_AXI_WREADY && n < TIMEOUT) begin @(negedge ACLK); n++; end
      if (n >= TIMEOUT) checkOutput("wReadyTimeout", 64'(n), 64'd0);
      @(negedge ACLK);
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_BVALID && n < TIMEOUT) begin @(negedge ACLK); n++; end
    if (n >= TIMEOUT) checkOutput("bValidTimeout", 64'(n), 64'd0);
    resp = S_AXI_BRESP; rid = S_AXI_BID;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
  endtask

  // Full read burst into rdData/rdResp/rdLast/rdId; with stall set, even beats
  // are held for one cycle with RREADY low and sampled into stData first.
  task automatic readBurst(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input bit stall);
    int n;
    sendAr(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      S_AXI_RREADY = !(stall && (i % 2 == 0));
      n = 0;
      while (!S_AXI_RVALID && n < TIMEOUT) begin @(negedge ACLK); n++; end
      if (n >= TIMEOUT) checkOutput("rValidTimeout", 64'(n), 64'd0);
      if (!S_AXI_RREADY) begin
        stData[i] = S_AXI_RDATA;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b1;
      end
      rdData[i] = S_AXI_RDATA; rdResp[i] = S_AXI_RRESP;
      rdLast[i] = S_AXI_RLAST; rdId[i]   = S_AXI_RID;
      @(negedge ACLK);
    end
    S_AXI_RREADY = 1'b0;
  endtask

  // Main directed sequence
  initial begin
    ARESET = 1'b1;
    S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0;
    S_AXI_AWBURST = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = '0;
    S_AXI_ARBURST = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

    repeat (3) @(negedge ACLK);
    checkOutput("resetOutputsZero", allOutputs(), 64'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    checkOutput("awReadyAfterReset", 64'(S_AXI_AWREADY), 64'd1);
    checkOutput("arReadyAfterReset", 64'(S_AXI_ARREADY), 64'd1);

    // Single INCR write and read back
    wrBuf[0] = 32'hDEADBEEF;
    applyStimulus(4'd3, 32'h10, 8'd0, 3'b010, 2'b01, 4'hF, 0, bResp, bId);
    checkOutput("singleBresp", 64'(bResp), 64'd0);
    checkOutput("singleBid", 64'(bId), 64'd3);
    readBurst(4'd5, 32'h10, 8'd0, 3'b010, 2'b01, 1'b0);
    checkOutput("singleRdata", 64'(rdData[0]), 64'hDEADBEEF);
    checkOutput("singleRresp", 64'(rdResp[0]), 64'd0);
    checkOutput("singleRlast", 64'(rdLast[0]), 64'd1);
    checkOutput("singleRid", 64'(rdId[0]), 64'd5);

    // 16-beat INCR burst, read back with RREADY stalls
    for (int i = 0; i < 16; i++) wrBuf[i] = 32'(i);
    applyStimulus(4'd1, 32'h100, 8'd15, 3'b010, 2'b01, 4'hF, 15, bResp, bId);
    checkOutput("burst16Bresp", 64'(bResp), 64'd0);
    readBurst(4'd6, 32'h100, 8'd15, 3'b010, 2'b01, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("burst16Data[%0d]", i), 64'(rdData[i]), 64'(i));
      checkOutput($sformatf("burst16Last[%0d]", i), 64'(rdLast[i]), 64'(i == 15));
      checkOutput($sformatf("burst16Resp[%0d]", i), 64'(rdResp[i]), 64'd0);
      if (i % 2 == 0)
        checkOutput($sformatf("burst16Stall[%0d]", i), 64'(stData[i]), 64'(i));
    end

    // Byte strobes
    wrBuf[0] = 32'hFFFFFFFF;
    applyStimulus(4'd2, 32'h20, 8'd0, 3'b010, 2'b01, 4'hF, 0, bResp, bId);
    wrBuf[0] = 32'h11223344;
    applyStimulus(4'd2, 32'h20, 8'd0, 3'b010, 2'b01, 4'b0101, 0, bResp, bId);
    readBurst(4'd2, 32'h20, 8'd0, 3'b010, 2'b01, 1'b0);
    checkOutput("strobeData", 64'(rdData[0]), 64'hFF22FF44);

    // FIXED burst: last beat wins; FIXED read repeats the same word
    for (int i = 0; i < 4; i++) wrBuf[i] = 32'(i + 1);
    applyStimulus(4'd2, 32'h30, 8'd3, 3'b010, 2'b00, 4'hF, 3, bResp, bId);
    checkOutput("fixedBresp", 64'(bResp), 64'd0);
    readBurst(4'd2, 32'h30, 8'd2, 3'b010, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("fixedData[%0d]", i), 64'(rdData[i]), 64'd4);
      checkOutput($sformatf("fixedLast[%0d]", i), 64'(rdLast[i]), 64'(i == 2));
    end

    // Read crossing the end of memory
    wrBuf[0] = 32'hA5A50001; wrBuf[1] = 32'hA5A50002;
    applyStimulus(4'd4, 32'((MEM_WORDS - 2) * 4), 8'd1, 3'b010, 2'b01, 4'hF, 1, bResp, bId);
    checkOutput("edgeWriteBresp", 64'(bResp), 64'd0);
    readBurst(4'd4, 32'((MEM_WORDS - 2) * 4), 8'd3, 3'b010, 2'b01, 1'b0);
    checkOutput("edgeData0", 64'(rdData[0]), 64'hA5A50001);
    checkOutput("edgeData1", 64'(rdData[1]), 64'hA5A50002);
    checkOutput("edgeResp01", 64'({rdResp[0], rdResp[1]}), 64'd0);
    checkOutput("edgeData23", 64'({rdData[2], rdData[3]}), 64'd0);
    checkOutput("edgeResp23", 64'({rdResp[2], rdResp[3]}), 64'b1010);
    checkOutput("edgeLast", 64'({rdLast[0], rdLast[1], rdLast[2], rdLast[3]}), 64'b0001);

    // Bad AWSIZE: SLVERR and memory left untouched
    wrBuf[0] = 32'h12345678;
    applyStimulus(4'd0, 32'h10, 8'd0, 3'b001, 2'b01, 4'hF, 0, bResp, bId);
    checkOutput("badSizeBresp", 64'(bResp), 64'd2);
    readBurst(4'd0, 32'h10, 8'd0, 3'b010, 2'b01, 1'b0);
    checkOutput("badSizeMemKept", 64'(rdData[0]), 64'hDEADBEEF);

    // Reserved burst type on both channels
    applyStimulus(4'd0, 32'h40, 8'd0, 3'b010, 2'b10, 4'hF, 0, bResp, bId);
    checkOutput("badBurstBresp", 64'(bResp), 64'd2);
    readBurst(4'd9, 32'h10, 8'd0, 3'b010, 2'b11, 1'b0);
    checkOutput("badBurstRresp", 64'(rdResp[0]), 64'd2);
    checkOutput("badBurstRdata", 64'(rdData[0]), 64'd0);

    // Early WLAST on beat 1 of a 4-beat burst
    for (int i = 0; i < 4; i++) wrBuf[i] = 32'h50 + 32'(i);
    applyStimulus(4'd8, 32'h50, 8'd3, 3'b010, 2'b01, 4'hF, 1, bResp, bId);
    checkOutput("earlyWlastBresp", 64'(bResp), 64'd2);
    checkOutput("earlyWlastBid", 64'(bId), 64'd8);

    // Concurrent write and read on disjoint regions
    for (int i = 0; i < 8; i++) wrBuf[i] = 32'h1000 + 32'(i);
    fork
      applyStimulus(4'd7, 32'h200, 8'd7, 3'b010, 2'b01, 4'hF, 7, bResp, bId);
      readBurst(4'd9, 32'h100, 8'd7, 3'b010, 2'b01, 1'b0);
    join
    checkOutput("concBresp", 64'(bResp), 64'd0);
    checkOutput("concBid", 64'(bId), 64'd7);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("concRdata[%0d]", i), 64'(rdData[i]), 64'(i));
      checkOutput($sformatf("concRid[%0d]", i), 64'(rdId[i]), 64'd9);
    end
    readBurst(4'd1, 32'h200, 8'd7, 3'b010, 2'b01, 1'b0);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("concWritten[%0d]", i), 64'(rdData[i]), 64'h1000 + 64'(i));

    // Reset in the middle of a read burst and a write burst
    sendAr(4'd2, 32'h100, 8'd15, 3'b010, 2'b01);
    sendAw(4'd4, 32'h300, 8'd3, 3'b010, 2'b01);
    S_AXI_WDATA = 32'hBAD0BAD0; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    checkOutput("midBurstRvalid", 64'(S_AXI_RVALID), 64'd1);
    checkOutput("midBurstWready", 64'(S_AXI_WREADY), 64'd1);
    #2 ARESET = 1'b1;
    #1 checkOutput("asyncResetOutputsZero", allOutputs(), 64'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    checkOutput("postResetReady", 64'({S_AXI_AWREADY, S_AXI_ARREADY}), 64'b11);
    checkOutput("postResetIdle", 64'({S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID}), 64'd0);

    wrBuf[0] = 32'hCAFEF00D;
    applyStimulus(4'd5, 32'h60, 8'd0, 3'b010, 2'b01, 4'hF, 0, bResp, bId);
    checkOutput("postResetBresp", 64'(bResp), 64'd0);
    checkOutput("postResetBid", 64'(bId), 64'd5);
    readBurst(4'd6, 32'h60, 8'd0, 3'b010, 2'b01, 1'b0);
    checkOutput("postResetRdata", 64'(rdData[0]), 64'hCAFEF00D);
    readBurst(4'd6, 32'h10, 8'd0, 3'b010, 2'b01, 1'b0);
    checkOutput("retained0x10", 64'(rdData[0]), 64'hDEADBEEF);
    readBurst(4'd6, 32'h20, 8'd0, 3'b010, 2'b01, 1'b0);
    checkOutput("retained0x20", 64'(rdData[0]), 64'hFF22FF44);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
